// File: rtl/wt_dcache_pkg.sv
// Shared definitions for the write-through data cache.
// Holds word/line widths, address field widths and the controller state
// encoding used by wt_dcache and dcache_array.
package wt_dcache_pkg;

  localparam int unsigned WORD_SIZE      = 16;
  localparam int unsigned LINE_SIZE      = 64;
  localparam int unsigned TAG_W          = 12;
  localparam int unsigned INDEX_W        = 2;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned NUM_LINES      = 1 << INDEX_W;
  localparam int unsigned WORDS_PER_LINE = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWthru = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag / valid / data storage for the direct-mapped data cache.
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset (clears valid bits only)
//   i_rd_index                combinational read index
//   o_rd_tag/valid/line       tag, valid bit and 64-bit line at i_rd_index
//   i_line_we/index/tag/data  whole-line install (sets valid)
//   i_word_we/index/offset/data  single-word update of an existing line
module dcache_array
  import wt_dcache_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [INDEX_W-1:0]   i_rd_index,
  output logic [TAG_W-1:0]     o_rd_tag,
  output logic                 o_rd_valid,
  output logic [LINE_SIZE-1:0] o_rd_line,
  input  logic                 i_line_we,
  input  logic [INDEX_W-1:0]   i_line_index,
  input  logic [TAG_W-1:0]     i_line_tag,
  input  logic [LINE_SIZE-1:0] i_line_data,
  input  logic                 i_word_we,
  input  logic [INDEX_W-1:0]   i_word_index,
  input  logic [OFFSET_W-1:0]  i_word_offset,
  input  logic [WORD_SIZE-1:0] i_word_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_SIZE-1:0] r_data [NUM_LINES];
  logic [5:0]           w_word_sel;

  assign w_word_sel = {i_word_offset, 4'b0000};

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_line_we) begin
      r_valid[i_line_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_tag[i_line_index]  <= i_line_tag;
      r_data[i_line_index] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_word_index][w_word_sel +: WORD_SIZE] <= i_word_data;
    end
  end

endmodule

// File: rtl/wt_dcache.sv
// Direct-mapped, write-through, write-allocate data cache (4 lines x 4 words x 16 bits).
// Ports:
//   i_clk, i_reset_n              clock, synchronous active-low reset
//   i_read_cache, i_write_cache   CPU load/store request, held until o_stall is low
//   i_address, i_cpu_wdata        word address {tag,index,offset} and store data
//   o_cpu_rdata, o_stall          load data and combinational stall
//   o_mem_address                 line address {tag,index,2'b00}
//   o_mem_read_m, o_mem_write_m   line read / line write strobes, held MEM_LATENCY cycles
//   i_mem_rdata, o_mem_wdata      fill line in, write-through line out
// Optional feature: define DCACHE_STATS_EN to add o_hit_count / o_miss_count.
module wt_dcache
  import wt_dcache_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_read_cache,
  input  logic                 i_write_cache,
  input  logic [15:0]          i_address,
  input  logic [WORD_SIZE-1:0] i_cpu_wdata,
  output logic [WORD_SIZE-1:0] o_cpu_rdata,
  output logic                 o_stall,
  output logic [15:0]          o_mem_address,
  output logic                 o_mem_read_m,
  output logic                 o_mem_write_m,
  input  logic [LINE_SIZE-1:0] i_mem_rdata,
`ifdef DCACHE_STATS_EN
  output logic [15:0]          o_hit_count,
  output logic [15:0]          o_miss_count,
`endif
  output logic [LINE_SIZE-1:0] o_mem_wdata
);

  localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

  state_e               r_state, w_state_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic [TAG_W-1:0]     r_tag;
  logic [INDEX_W-1:0]   r_index;
  logic [LINE_SIZE-1:0] r_wdata;
  logic                 r_wdone, w_wdone_next;

  logic [TAG_W-1:0]     w_tag, w_rd_tag;
  logic [INDEX_W-1:0]   w_index;
  logic [OFFSET_W-1:0]  w_offset;
  logic [5:0]           w_word_sel;
  logic                 w_rd_valid, w_hit;
  logic [LINE_SIZE-1:0] w_rd_line, w_merged;
  logic                 w_line_we, w_word_we, w_capture;

  assign w_tag      = i_address[15:4];
  assign w_index    = i_address[3:2];
  assign w_offset   = i_address[1:0];
  assign w_word_sel = {w_offset, 4'b0000};

  dcache_array u_array (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_rd_index    (w_index),
    .o_rd_tag      (w_rd_tag),
    .o_rd_valid    (w_rd_valid),
    .o_rd_line     (w_rd_line),
    .i_line_we     (w_line_we),
    .i_line_index  (r_index),
    .i_line_tag    (r_tag),
    .i_line_data   (i_mem_rdata),
    .i_word_we     (w_word_we),
    .i_word_index  (w_index),
    .i_word_offset (w_offset),
    .i_word_data   (i_cpu_wdata)
  );

  assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
  assign o_cpu_rdata = w_rd_line[w_word_sel +: WORD_SIZE];

  always_comb begin
    w_merged = w_rd_line;
    w_merged[w_word_sel +: WORD_SIZE] = i_cpu_wdata;
  end

  // Idle uses the live CPU address; memory accesses use the address latched at the decision.
  assign o_mem_address = (r_state == StIdle) ? {w_tag, w_index, 2'b00} : {r_tag, r_index, 2'b00};
  assign o_mem_wdata   = r_wdata;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_wdone_next  = 1'b0;
    o_stall       = 1'b0;
    o_mem_read_m  = 1'b0;
    o_mem_write_m = 1'b0;
    w_line_we     = 1'b0;
    w_word_we     = 1'b0;
    w_capture     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_write_cache) begin
          // r_wdone marks the cycle right after a finished write-through: the store is done.
          if (!r_wdone) begin
            o_stall    = 1'b1;
            w_capture  = 1'b1;
            w_cnt_next = '0;
            if (w_hit) begin
              w_word_we    = 1'b1;
              w_state_next = StWthru;
            end else begin
              w_state_next = StFill;
            end
          end
        end else if (i_read_cache && !w_hit) begin
          o_stall      = 1'b1;
          w_capture    = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StFill;
        end
      end
      StFill: begin
        o_stall      = 1'b1;
        o_mem_read_m = 1'b1;
        if (r_cnt == LastCnt) begin
          w_line_we    = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StWthru: begin
        o_stall       = 1'b1;
        o_mem_write_m = 1'b1;
        if (r_cnt == LastCnt) begin
          w_wdone_next = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_wdone <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_wdone <= w_wdone_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_tag   <= w_tag;
      r_index <= w_index;
      r_wdata <= w_merged;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_filled;
  logic        w_count;
  logic [15:0] r_hit_count, r_miss_count;

  // Only the first idle decision of a request counts; retries after a fill or
  // the completion cycle after a write-through do not.
  assign w_count = (r_state == StIdle) && (i_read_cache || i_write_cache) && !r_filled &&
                   !(i_write_cache && r_wdone);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_filled     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_filled <= w_line_we;
      if (w_count) begin
        if (w_hit) begin
          r_hit_count <= r_hit_count + 16'd1;
        end else begin
          r_miss_count <= r_miss_count + 16'd1;
        end
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_wt_dcache.sv
module tb_wt_dcache;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        reset_n, rd, wr;
  logic [15:0] addr, wdata, rdata, maddr;
  logic        stall, mrd, mwr;
  logic [63:0] mrdata = '0;
  logic [63:0] mwdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hitc, missc;
`endif

  always #5 clk = ~clk;

  wt_dcache #(.MEM_LATENCY(L)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_read_cache  (rd),
    .i_write_cache (wr),
    .i_address     (addr),
    .i_cpu_wdata   (wdata),
    .o_cpu_rdata   (rdata),
    .o_stall       (stall),
    .o_mem_address (maddr),
    .o_mem_read_m  (mrd),
    .o_mem_write_m (mwr),
    .i_mem_rdata   (mrdata),
`ifdef DCACHE_STATS_EN
    .o_hit_count   (hitc),
    .o_miss_count  (missc),
`endif
    .o_mem_wdata   (mwdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        chk_rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  // Cache and memory model: contents only, timing comes from the request rules.
  bit          m_valid [4];
  logic [11:0] m_tag   [4];
  logic [63:0] m_line  [4];
  logic [63:0] m_mem   [logic [15:0]];
  int          m_hits = 0;
  int          m_misses = 0;

  // Untouched memory: line 0004 holds words 1,2,3,4 (word 0 lowest).
  function automatic logic [63:0] mem_line(input logic [15:0] la);
    logic [63:0] l;
    if (m_mem.exists(la)) return m_mem[la];
    for (int n = 0; n < 4; n++) l[16*n +: 16] = 16'(n + 1) + 16'((la - 16'h4) << 2);
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic s, input logic r, input logic w, input logic [15:0] a,
                               input logic [63:0] wd, input logic c, input logic [15:0] rv);
    exp_t e;
    e.stall = s; e.rd = r; e.wr = w; e.addr = a; e.wdata = wd; e.chk_rd = c; e.rdata = rv;
    exp_q.push_back(e);
  endfunction

  // Memory responds from the model; the compare process checks one expected cycle per clock.
  always @(negedge clk) begin
    mrdata = mem_line(maddr);
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stall", {63'd0, stall}, {63'd0, cur.stall});
      chk("mem_readM", {63'd0, mrd}, {63'd0, cur.rd});
      chk("mem_writeM", {63'd0, mwr}, {63'd0, cur.wr});
      if (cur.rd || cur.wr) chk("mem_address", {48'd0, maddr}, {48'd0, cur.addr});
      if (cur.wr) chk("mem_wdata", mwdata, cur.wdata);
      if (cur.chk_rd) chk("cpu_rdata", {48'd0, rdata}, {48'd0, cur.rdata});
    end
  end

  // Builds the expected per-cycle trace of one request, then drives it for that many cycles.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] wd,
                        output int ncyc, output logic [63:0] wline);
    int          idx, off;
    logic [15:0] la;
    bit          hit;
    idx   = int'(a[3:2]);
    off   = int'(a[1:0]);
    la    = {a[15:2], 2'b00};
    hit   = m_valid[idx] && (m_tag[idx] == a[15:4]);
    wline = '0;
    if (r || w) begin
      if (hit) m_hits++;
      else m_misses++;
      push(1'b1, 1'b0, 1'b0, la, '0, 1'b0, '0);
      if (!hit) begin
        for (int i = 0; i < int'(L); i++) push(1'b1, 1'b1, 1'b0, la, '0, 1'b0, '0);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[15:4];
        m_line[idx]  = mem_line(la);
        // A store revisits idle after the fill and now sees a hit.
        if (w) push(1'b1, 1'b0, 1'b0, la, '0, 1'b0, '0);
      end
      if (w) begin
        wline = m_line[idx];
        wline[16*off +: 16] = wd;
        m_line[idx] = wline;
        for (int i = 0; i < int'(L); i++) push(1'b1, 1'b0, 1'b1, la, wline, 1'b0, '0);
        push(1'b0, 1'b0, 1'b0, la, '0, 1'b0, '0);
      end else begin
        // A hit needs no stall cycle at all: drop the speculative one pushed above.
        if (hit) void'(exp_q.pop_back());
        push(1'b0, 1'b0, 1'b0, la, '0, 1'b1, m_line[idx][16*off +: 16]);
      end
    end else begin
      push(1'b0, 1'b0, 1'b0, la, '0, 1'b0, '0);
    end
    ncyc  = exp_q.size();
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = wd;
    repeat (ncyc) @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    if (w) m_mem[la] = wline;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin
    int          n;
    logic [63:0] wl;
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_mem_readM", {63'd0, mrd}, 64'd0);
    chk("reset_mem_writeM", {63'd0, mwr}, 64'd0);
`ifdef DCACHE_STATS_EN
    chk("reset_hit_count", {48'd0, hitc}, 64'd0);
    chk("reset_miss_count", {48'd0, missc}, 64'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Read miss: stall L+1 cycles, then the hit cycle returns word 1 of line 0004.
    do_req(1'b1, 1'b0, 16'h0005, 16'h0, n, wl);
    chk("read_miss_cycles", 64'(n), 64'(L + 2));
    chk("model_fill_line", m_line[1], 64'h0004_0003_0002_0001);
    do_req(1'b1, 1'b0, 16'h0006, 16'h0, n, wl);
    chk("read_hit_cycles", 64'(n), 64'd1);
    do_req(1'b0, 1'b1, 16'h0004, 16'hBEEF, n, wl);
    chk("write_hit_cycles", 64'(n), 64'(L + 2));
    chk("model_wthru_line", wl, 64'h0004_0003_0002_BEEF);
    do_req(1'b1, 1'b0, 16'h0004, 16'h0, n, wl);
    chk("read_after_write_cycles", 64'(n), 64'd1);
    chk("model_beef_word", {48'd0, m_line[1][15:0]}, 64'h0000_0000_0000_BEEF);
`ifdef DCACHE_STATS_EN
    chk("hit_count", {48'd0, hitc}, 64'd3);
    chk("miss_count", {48'd0, missc}, 64'd1);
`endif

    // Conflict write miss on index 1, then the old line misses again.
    do_req(1'b0, 1'b1, 16'h0014, 16'h1234, n, wl);
    chk("write_miss_cycles", 64'(n), 64'(2 * L + 3));
    do_req(1'b1, 1'b0, 16'h0005, 16'h0, n, wl);
    chk("reread_miss_cycles", 64'(n), 64'(L + 2));

    // Idle cycles, a fresh index, and both strobes high (treated as a store).
    do_req(1'b0, 1'b0, 16'h0000, 16'h0, n, wl);
    do_req(1'b0, 1'b0, 16'h0000, 16'h0, n, wl);
    do_req(1'b1, 1'b0, 16'h0038, 16'h0, n, wl);
    do_req(1'b0, 1'b1, 16'h003B, 16'hCAFE, n, wl);
    do_req(1'b1, 1'b1, 16'h0039, 16'h5A5A, n, wl);
    chk("both_high_as_write_cycles", 64'(n), 64'(L + 2));
    do_req(1'b1, 1'b0, 16'h0039, 16'h0, n, wl);
    do_req(1'b1, 1'b0, 16'h003B, 16'h0, n, wl);
    do_req(1'b1, 1'b0, 16'h0014, 16'h0, n, wl);
    chk("model_1234_word", {48'd0, m_line[1][15:0]}, 64'h0000_0000_0000_1234);
`ifdef DCACHE_STATS_EN
    chk("hit_count_model", {48'd0, hitc}, 64'(m_hits));
    chk("miss_count_model", {48'd0, missc}, 64'(m_misses));
`endif

    // Reset asserted during the second fill cycle of a miss to 0025.
    rd = 1'b1; addr = 16'h0025;
    @(negedge clk);
    chk("rst_fill_idle_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    chk("rst_fill_c1_readM", {63'd0, mrd}, 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0; rd = 1'b0;
    @(negedge clk);
    chk("rst_fill_c2_readM", {63'd0, mrd}, 64'd1);
    @(negedge clk);
    chk("rst_after_stall", {63'd0, stall}, 64'd0);
    chk("rst_after_readM", {63'd0, mrd}, 64'd0);
    chk("rst_after_writeM", {63'd0, mwr}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    do_req(1'b1, 1'b0, 16'h0005, 16'h0, n, wl);
    chk("post_reset_miss_cycles", 64'(n), 64'(L + 2));
    do_req(1'b1, 1'b0, 16'h0025, 16'h0, n, wl);
    chk("aborted_fill_not_installed", 64'(n), 64'(L + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wt_dcache.md
WT_DCACHE -- requirements
Module: wt_dcache

Interface
REQ-001 Parameter MEM_LATENCY, default 4, memory access duration in cycles (legal 2..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 readCache  input  1  CPU MEM-stage load request, level, held until stall low.
REQ-005 writeCache  input  1  CPU MEM-stage store request, level, held until stall low.
REQ-006 address  input  16  CPU word address: tag[15:4], index[3:2], offset[1:0].
REQ-007 cpu_wdata  input  16  store data.
REQ-008 cpu_rdata  output  16  load data, valid when readCache=1 and stall=0.
REQ-009 stall  output  1  combinational; high while the request cannot complete this cycle.
REQ-010 mem_address  output  16  line address {tag,index,2'b00}.
REQ-011 mem_readM / mem_writeM  output  1 each  memory line read / line write strobe, held for the whole access.
REQ-012 mem_rdata  input  64  fill line, sampled in the last access cycle.
REQ-013 mem_wdata  output  64  write-through line, word n at bits [16n+15:16n].

Function
REQ-014 Organisation: direct-mapped, 4 lines x 4 words x 16 bits, 12-bit tag + valid bit per line, write-through, write-allocate.
REQ-015 FSM states IDLE, FILL, WTHRU; counter 4 bits counts MEM_LATENCY cycles per memory access.
REQ-016 IDLE read hit: cpu_rdata = line[index].word[offset] combinationally, stall=0, no memory strobe.
REQ-017 IDLE miss (read or write): stall=1 same cycle, go FILL; mem_readM=1 for exactly MEM_LATENCY cycles; on last cycle line, tag, valid written; return IDLE.
REQ-018 Read miss penalty: stall high for MEM_LATENCY+1 cycles; access then completes as hit.
REQ-019 IDLE write hit: stall=1, go WTHRU; mem_writeM=1, mem_wdata = stored line with cpu_wdata merged at offset, for MEM_LATENCY cycles; cache word updated on entry to WTHRU; stall drops the cycle after WTHRU ends.
REQ-020 Write miss: FILL then WTHRU back-to-back (via IDLE hit detection); stall high throughout.
REQ-021 readCache and writeCache both high: treated as write.
REQ-022 No request: stall=0, strobes 0, state IDLE.
REQ-023 mem_readM and mem_writeM never simultaneously high.
REQ-024 Request dropped mid-FILL: fill completes and line is installed; dropped mid-WTHRU: write-through completes.

Reset
REQ-025 reset_n=0 at an edge: state IDLE, counter 0, all valid bits 0, strobes 0 after that edge; overrides any in-flight access.
REQ-026 Data and tag arrays need no reset; cpu_rdata is don't-care while stall=1 or no read.

Configuration
REQ-027 Macro DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (16 bits each, wrap at 16'hFFFF to 0), incremented once per completed request at the IDLE decision; cleared by reset.
REQ-028 Macro DCACHE_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package holds WORD_SIZE=16, LINE_SIZE=64, tag/index/offset field widths, FSM state encoding.
REQ-030 One sub-module dcache_array: tag/valid/data storage with combinational read and synchronous line/word write.

Verification
REQ-031 Reset, read 16'h0005 (mem line 0004 = 64'h0004_0003_0002_0001 word order 3..0), MEM_LATENCY=4 -> stall high 5 cycles, mem_readM 4 cycles at mem_address 16'h0004, then cpu_rdata=16'h0002.
REQ-032 Read 16'h0006 immediately after -> hit, stall=0, cpu_rdata=16'h0003, no strobe.
REQ-033 Write 16'hBEEF to 16'h0004 -> mem_writeM 4 cycles, mem_wdata=64'h0004_0003_0002_BEEF; later read 16'h0004 -> 16'hBEEF without stall.
REQ-034 Write to 16'h0014 (conflict miss, index 1) -> FILL 4 cycles then WTHRU 4 cycles; following read 16'h0005 misses again.
REQ-035 reset_n low on cycle 2 of a FILL -> next cycle strobes 0, stall 0 idle; read of 16'h0005 misses.
REQ-036 With DCACHE_STATS_EN: sequence REQ-031..033 -> hit_count=3, miss_count=1 (write hit counted at IDLE decision).
